// File: rtl/snl_move_monitor_if.sv
// ---------------------------------------------------------------------------
// snl_move_monitor_if
// Move-event stream from the monitor to the display/logging logic.
//   evt_valid  head event present (monitor -> consumer)
//   evt_ready  consumer accepts the head event this cycle (consumer -> monitor)
//   evt_type   00 STEP, 01 LADDER, 10 SNAKE, 11 ERROR
//   evt_win    head event coincided with the win assertion
//   evt_from   square before the move
//   evt_to     square after the move
// master = event producer (the monitor), slave = event consumer.
// ---------------------------------------------------------------------------
interface snl_move_monitor_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic       evt_win;
  logic [6:0] evt_from;
  logic [6:0] evt_to;

  modport master (
    output evt_valid, evt_type, evt_win, evt_from, evt_to,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_type, evt_win, evt_from, evt_to,
    output evt_ready
  );
endinterface

// File: rtl/snl_move_monitor.sv
// ---------------------------------------------------------------------------
// snl_move_monitor
// Watches the game core's player position and win flag, classifies every
// position change (STEP / LADDER / SNAKE / ERROR), and queues the move events
// in a small FIFO drained through a valid/ready interface. Also counts turns,
// latches game-over, and flags dropped events.
// Ports:
//   clk         rising-edge clock shared with the game core
//   reset       asynchronous, active-low reset (0 = reset)
//   player_pos  current square from the game core
//   win         game core win flag
//   evt         move-event stream (master side of snl_move_monitor_if)
//   turn_count  moves detected since reset, saturating
//   game_over   high from the cycle after win is first seen until reset
//   overflow    sticky, set when an event is dropped on a full FIFO
// ---------------------------------------------------------------------------
module snl_move_monitor #(
  parameter int BOARD_MAX  = 100,
  parameter int MAX_DIE    = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int TURN_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               player_pos,
  input  logic                     win,
  snl_move_monitor_if.master       evt,
  output logic [TURN_W-1:0]        turn_count,
  output logic                     game_over,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [6:0] C_BOARD_MAX = 7'(BOARD_MAX);
  localparam logic [6:0] C_MAX_DIE   = 7'(MAX_DIE);

  localparam logic [1:0] EVT_STEP   = 2'b00;
  localparam logic [1:0] EVT_LADDER = 2'b01;
  localparam logic [1:0] EVT_SNAKE  = 2'b10;
  localparam logic [1:0] EVT_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_PLAY,
    ST_OVER
  } state_t;

  typedef struct packed {
    logic [1:0] kind;
    logic       win;
    logic [6:0] from;
    logic [6:0] to;
  } event_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [6:0]          r_prev_pos;
  logic [TURN_W-1:0]   r_turn;
  logic                r_game_over;
  logic                r_overflow;
  event_t              r_mem [FIFO_DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;

  logic                w_changed;
  logic                w_detect;
  logic [6:0]          w_delta;
  event_t              w_event;
  event_t              w_head;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  assign w_changed = (player_pos != r_prev_pos);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and move detection. game_over is always 0 while in PLAY, so
  // "win && !game_over" reduces to plain win here.
  always_comb begin
    w_next_state = r_state;
    w_detect     = 1'b0;
    case (r_state)
      ST_ARM: begin
        w_next_state = ST_PLAY;
      end
      ST_PLAY: begin
        w_detect = w_changed || win;
        if (win) begin
          w_next_state = ST_OVER;
        end
      end
      ST_OVER: begin
        w_next_state = ST_OVER;
      end
      default: begin
        w_next_state = ST_ARM;
      end
    endcase
  end

  // Classify the candidate move; order matters (invalid square beats snake).
  // A win without movement has from == to and therefore falls through to STEP.
  always_comb begin
    w_delta      = player_pos - r_prev_pos;
    w_event.win  = win;
    w_event.from = r_prev_pos;
    w_event.to   = player_pos;
    if ((player_pos > C_BOARD_MAX) || (player_pos == 7'd0)) begin
      w_event.kind = EVT_ERROR;
    end else if (player_pos < r_prev_pos) begin
      w_event.kind = EVT_SNAKE;
    end else if (w_delta > C_MAX_DIE) begin
      w_event.kind = EVT_LADDER;
    end else begin
      w_event.kind = EVT_STEP;
    end
  end

  // FIFO status. A pop frees a slot in the same cycle, so a full FIFO can
  // still take a push; a pop on an empty FIFO never happens.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_pop   = !w_empty && evt.evt_ready;
  assign w_push  = w_detect && (!w_full || w_pop);

  // Position tracking, turn counter, game-over and overflow flags. Dropped
  // events still advance prev_pos and the turn count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_pos  <= '0;
      r_turn      <= '0;
      r_game_over <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == ST_ARM) begin
        r_prev_pos <= player_pos;
      end else if (r_state == ST_PLAY) begin
        if (w_detect) begin
          r_prev_pos <= player_pos;
        end
        if (w_changed && (r_turn != '1)) begin
          r_turn <= r_turn + 1'b1;
        end
        if (win) begin
          r_game_over <= 1'b1;
        end
        if (w_detect && !w_push) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Event storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= w_event;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Head event driven from registers only; zeroed while the FIFO is empty.
  assign w_head        = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign evt.evt_valid = !w_empty;
  assign evt.evt_type  = w_empty ? 2'b00 : w_head.kind;
  assign evt.evt_win   = w_empty ? 1'b0  : w_head.win;
  assign evt.evt_from  = w_empty ? 7'd0  : w_head.from;
  assign evt.evt_to    = w_empty ? 7'd0  : w_head.to;

  assign turn_count = r_turn;
  assign game_over  = r_game_over;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_snl_move_monitor.sv
// ---------------------------------------------------------------------------
// tb_snl_move_monitor
// Directed bench for snl_move_monitor: moves, classification, FIFO
// back-pressure and overflow, win / game-over, and mid-game reset.
// ---------------------------------------------------------------------------
module tb_snl_move_monitor;

  localparam logic [1:0] STEP   = 2'b00;
  localparam logic [1:0] LADDER = 2'b01;
  localparam logic [1:0] SNAKE  = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic       clk;
  logic       reset;
  logic [6:0] player_pos;
  logic       win;
  logic [7:0] turn_count;
  logic       game_over;
  logic       overflow;

  int checkCount;
  int errorCount;

  snl_move_monitor_if ev ();

  snl_move_monitor #(
    .BOARD_MAX  (100),
    .MAX_DIE    (6),
    .FIFO_DEPTH (4),
    .TURN_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .player_pos (player_pos),
    .win        (win),
    .evt        (ev),
    .turn_count (turn_count),
    .game_over  (game_over),
    .overflow   (overflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the observed head event as {valid, type, win, from, to}.
  function automatic logic [17:0] head();
    return {ev.evt_valid, ev.evt_type, ev.evt_win, ev.evt_from, ev.evt_to};
  endfunction

  // Builds an expected head-event vector in the same packing.
  function automatic logic [17:0] expEvt(input logic v, input logic [1:0] t, input logic w,
                                         input logic [6:0] f, input logic [6:0] to);
    return {v, t, w, f, to};
  endfunction

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic [6:0] p, input logic w, input logic r);
    player_pos   = p;
    win          = w;
    ev.evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given core position, release after an edge.
  task automatic applyReset(input logic [6:0] p);
    reset        = 1'b0;
    player_pos   = p;
    win          = 1'b0;
    ev.evt_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    applyReset(7'd0);
    checkCount++;
    if ({head(), turn_count, game_over, overflow} !== {18'd0, 8'd0, 1'b0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL reset_state: got evt=%h turn=%0d go=%b ovf=%b, expected all zero",
               head(), turn_count, game_over, overflow);
    end
  endtask

  // Three STEP moves with the consumer always ready.
  task automatic test_steps();
    logic [17:0] exp;
    applyReset(7'd0);
    applyStimulus(7'd0, 1'b0, 1'b1);
    checkCount++;
    if (ev.evt_valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL arm_no_event: got valid=%b expected 0", ev.evt_valid);
    end
    applyStimulus(7'd1, 1'b0, 1'b1);
    exp = expEvt(1'b1, STEP, 1'b0, 7'd0, 7'd1);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL step_0_1: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd5, 1'b0, 1'b1);
    exp = expEvt(1'b1, STEP, 1'b0, 7'd1, 7'd5);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL step_1_5: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd9, 1'b0, 1'b1);
    exp = expEvt(1'b1, STEP, 1'b0, 7'd5, 7'd9);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL step_5_9: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd9, 1'b0, 1'b1);
    checkCount++;
    if ({ev.evt_valid, turn_count} !== {1'b0, 8'd3}) begin
      errorCount++;
      $display("[TB] FAIL steps_done: got valid=%b turn=%0d expected valid=0 turn=3",
               ev.evt_valid, turn_count);
    end
  endtask

  // Ladder, step, snake held under back-pressure, then die step of exactly
  // MAX_DIE (STEP) and MAX_DIE+1 (LADDER).
  task automatic test_ladder_snake();
    logic [17:0] exp;
    applyReset(7'd4);
    applyStimulus(7'd4, 1'b0, 1'b0);
    applyStimulus(7'd14, 1'b0, 1'b0);
    exp = expEvt(1'b1, LADDER, 1'b0, 7'd4, 7'd14);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL ladder_4_14: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd17, 1'b0, 1'b0);
    applyStimulus(7'd7, 1'b0, 1'b0);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL head_stable: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd7, 1'b0, 1'b1);
    exp = expEvt(1'b1, STEP, 1'b0, 7'd14, 7'd17);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL step_14_17: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd7, 1'b0, 1'b1);
    exp = expEvt(1'b1, SNAKE, 1'b0, 7'd17, 7'd7);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL snake_17_7: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd13, 1'b0, 1'b1);
    exp = expEvt(1'b1, STEP, 1'b0, 7'd7, 7'd13);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL step_max_die: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd20, 1'b0, 1'b1);
    exp = expEvt(1'b1, LADDER, 1'b0, 7'd13, 7'd20);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL ladder_min: got %h expected %h", head(), exp);
    end
    applyStimulus(7'd20, 1'b0, 1'b1);
    checkCount++;
    if ({ev.evt_valid, turn_count} !== {1'b0, 8'd5}) begin
      errorCount++;
      $display("[TB] FAIL ls_done: got valid=%b turn=%0d expected valid=0 turn=5",
               ev.evt_valid, turn_count);
    end
  endtask

  // Five moves into a 4-entry FIFO with no consumer: one drop.
  task automatic test_overflow();
    logic [17:0] exp;
    applyReset(7'd0);
    applyStimulus(7'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(7'(i), 1'b0, 1'b0);
    end
    checkCount++;
    if ({ev.evt_valid, overflow, turn_count} !== {1'b1, 1'b1, 8'd5}) begin
      errorCount++;
      $display("[TB] FAIL ovf_flags: got valid=%b ovf=%b turn=%0d expected 1 1 5",
               ev.evt_valid, overflow, turn_count);
    end
    for (int i = 0; i < 4; i++) begin
      exp = expEvt(1'b1, STEP, 1'b0, 7'(i), 7'(i + 1));
      checkCount++;
      if (head() !== exp) begin
        errorCount++;
        $display("[TB] FAIL ovf_drain_%0d: got %h expected %h", i, head(), exp);
      end
      applyStimulus(7'd5, 1'b0, 1'b1);
    end
    checkCount++;
    if ({ev.evt_valid, overflow} !== {1'b0, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL ovf_empty: got valid=%b ovf=%b expected valid=0 ovf=1",
               ev.evt_valid, overflow);
    end
  endtask

  // Full FIFO with a pop and a new move on the same edge.
  task automatic test_back_to_back();
    logic [17:0] exp;
    applyReset(7'd0);
    applyStimulus(7'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(7'(i), 1'b0, 1'b0);
    end
    applyStimulus(7'd5, 1'b0, 1'b1);
    checkCount++;
    if (overflow !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL b2b_no_ovf: got ovf=%b expected 0", overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      exp = expEvt(1'b1, STEP, 1'b0, 7'(i), 7'(i + 1));
      checkCount++;
      if (head() !== exp) begin
        errorCount++;
        $display("[TB] FAIL b2b_drain_%0d: got %h expected %h", i, head(), exp);
      end
      applyStimulus(7'd5, 1'b0, 1'b1);
    end
    checkCount++;
    if ({ev.evt_valid, overflow} !== {1'b0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL b2b_empty: got valid=%b ovf=%b expected 0 0", ev.evt_valid, overflow);
    end
  endtask

  // Winning move, then everything after it ignored.
  task automatic test_win();
    logic [17:0] exp;
    applyReset(7'd98);
    applyStimulus(7'd98, 1'b0, 1'b1);
    applyStimulus(7'd100, 1'b1, 1'b1);
    exp = expEvt(1'b1, STEP, 1'b1, 7'd98, 7'd100);
    checkCount++;
    if ({head(), game_over, turn_count} !== {exp, 1'b1, 8'd1}) begin
      errorCount++;
      $display("[TB] FAIL win_event: got %h go=%b turn=%0d expected %h go=1 turn=1",
               head(), game_over, turn_count, exp);
    end
    applyStimulus(7'd50, 1'b0, 1'b1);
    applyStimulus(7'd60, 1'b1, 1'b1);
    checkCount++;
    if ({ev.evt_valid, game_over, turn_count} !== {1'b0, 1'b1, 8'd1}) begin
      errorCount++;
      $display("[TB] FAIL over_frozen: got valid=%b go=%b turn=%0d expected 0 1 1",
               ev.evt_valid, game_over, turn_count);
    end
  endtask

  // Win without movement reports a from==to STEP.
  task automatic test_win_no_move();
    logic [17:0] exp;
    applyReset(7'd50);
    applyStimulus(7'd50, 1'b0, 1'b0);
    applyStimulus(7'd50, 1'b1, 1'b0);
    exp = expEvt(1'b1, STEP, 1'b1, 7'd50, 7'd50);
    checkCount++;
    if ({head(), game_over, turn_count} !== {exp, 1'b1, 8'd0}) begin
      errorCount++;
      $display("[TB] FAIL win_no_move: got %h go=%b turn=%0d expected %h go=1 turn=0",
               head(), game_over, turn_count, exp);
    end
  endtask

  // Off-board square, then asynchronous reset in mid-game.
  task automatic test_error_reset();
    logic [17:0] exp;
    applyReset(7'd10);
    applyStimulus(7'd10, 1'b0, 1'b0);
    applyStimulus(7'd120, 1'b0, 1'b0);
    exp = expEvt(1'b1, ERROR, 1'b0, 7'd10, 7'd120);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL error_120: got %h expected %h", head(), exp);
    end
    #2;
    reset = 1'b0;
    #1;
    checkCount++;
    if ({ev.evt_valid, turn_count, overflow} !== {1'b0, 8'd0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL async_reset: got valid=%b turn=%0d ovf=%b expected 0 0 0",
               ev.evt_valid, turn_count, overflow);
    end
    player_pos = 7'd33;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(7'd33, 1'b0, 1'b1);
    applyStimulus(7'd33, 1'b0, 1'b1);
    checkCount++;
    if ({ev.evt_valid, turn_count} !== {1'b0, 8'd0}) begin
      errorCount++;
      $display("[TB] FAIL rearm_no_event: got valid=%b turn=%0d expected 0 0",
               ev.evt_valid, turn_count);
    end
    applyStimulus(7'd0, 1'b0, 1'b0);
    exp = expEvt(1'b1, ERROR, 1'b0, 7'd33, 7'd0);
    checkCount++;
    if (head() !== exp) begin
      errorCount++;
      $display("[TB] FAIL error_zero: got %h expected %h", head(), exp);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    checkCount   = 0;
    errorCount   = 0;
    reset        = 1'b0;
    player_pos   = 7'd0;
    win          = 1'b0;
    ev.evt_ready = 1'b0;
    test_reset();
    test_steps();
    test_ladder_snake();
    test_overflow();
    test_back_to_back();
    test_win();
    test_win_no_move();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
